// File: rtl/pixel_writer.sv
// Pixel writer: queues in-range pixels into a small FIFO and drains them to a
// 1-bit framebuffer, with a full-screen clear-to-black sequencer.
module pixel_writer #(
   parameter int WIDTH  = 640,
   parameter int HEIGHT = 480,
   parameter int DEPTH  = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   input  logic [10:0] in_x,
   input  logic [10:0] in_y,
   input  logic        in_color,
   output logic        in_ready,
   input  logic        clear_req,
   output logic        clear_busy,
   output logic        fb_we,
   output logic [18:0] fb_addr,
   output logic        fb_data,
   input  logic        fb_ack,
   output logic [15:0] drop_count
);

   localparam int          AW        = $clog2(DEPTH);
   localparam logic [AW:0] FULL      = (AW+1)'(DEPTH);
   localparam logic [18:0] LAST_ADDR = 19'(WIDTH * HEIGHT - 1);

   typedef enum logic {RUN, CLEAR} state_e;

   state_e          state_q, state_d;
   logic [19:0]     mem_q [DEPTH];
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [AW:0]     cnt_q, cnt_d;
   logic            pend_q, pend_d;
   logic [18:0]     caddr_q, caddr_d;
   logic [15:0]     drop_q, drop_d;

   logic            in_range, accept, push, pop, wr_done, fifo_nempty;
   logic [18:0]     pix_addr;

   assign in_range    = ({21'd0, in_x} < 32'(WIDTH)) && ({21'd0, in_y} < 32'(HEIGHT));
   assign pix_addr    = 19'(in_y) * 19'(WIDTH) + 19'(in_x);
   assign fifo_nempty = (cnt_q != '0);

   // Ready ignores a same-cycle pop so the accept path never depends on fb_ack.
   assign in_ready    = (state_q == RUN) && (cnt_q != FULL);
   assign accept      = in_valid && in_ready;
   assign push        = accept && in_range;

   assign fb_we       = (state_q == CLEAR) || fifo_nempty;
   assign fb_addr     = (state_q == CLEAR) ? caddr_q : mem_q[rd_ptr_q][19:1];
   assign fb_data     = (state_q == RUN) && mem_q[rd_ptr_q][0];
   assign wr_done     = fb_we && fb_ack;
   assign pop         = (state_q == RUN) && wr_done;

   assign clear_busy  = pend_q || (state_q == CLEAR);
   assign drop_count  = drop_q;

   always_comb begin
      state_d  = state_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      pend_d   = pend_q;
      caddr_d  = caddr_q;
      drop_d   = drop_q;

      if (accept && !in_range && drop_q != 16'hFFFF)
         drop_d = drop_q + 16'd1;

      case (state_q)
         RUN: begin
            if (clear_req)
               pend_d = 1'b1;
            if (push)
               wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)
               rd_ptr_d = rd_ptr_q + AW'(1);
            cnt_d = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
            // Only switch on an idle or just-completed bus so fb_* never glitch mid-write.
            if (pend_q && (!fb_we || wr_done)) begin
               state_d  = CLEAR;
               pend_d   = 1'b0;
               wr_ptr_d = '0;
               rd_ptr_d = '0;
               cnt_d    = '0;
               caddr_d  = '0;
            end
         end
         CLEAR: begin
            if (wr_done) begin
               if (caddr_q == LAST_ADDR) begin
                  state_d = RUN;
                  caddr_d = '0;
               end else begin
                  caddr_d = caddr_q + 19'd1;
               end
            end
         end
         default: state_d = RUN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= RUN;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         pend_q   <= 1'b0;
         caddr_q  <= '0;
         drop_q   <= '0;
      end else begin
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         pend_q   <= pend_d;
         caddr_q  <= caddr_d;
         drop_q   <= drop_d;
      end
   end

   // Payload storage needs no reset; occupancy alone defines validity.
   always_ff @(posedge clk) begin
      if (push)
         mem_q[wr_ptr_q] <= {pix_addr, in_color};
   end

endmodule

// File: doc/pixel_writer.md
PIXEL_WRITER -- requirements
Module: pixel_writer

Interface
REQ-001 Parameter WIDTH, default 640, meaning visible pixel columns.
REQ-002 Parameter HEIGHT, default 480, meaning visible pixel rows.
REQ-003 Parameter DEPTH, default 8, meaning pixel FIFO entries (power of two, at least 2).
REQ-004 Port clk  input  1  clock; all state SHALL update on its rising edge.
REQ-005 Port reset  input  1  reset; synchronous, active-high.
REQ-006 Port in_valid  input  1  upstream pixel present.
REQ-007 Port in_x  input  11  pixel column.
REQ-008 Port in_y  input  11  pixel row.
REQ-009 Port in_color  input  1  0 = black, 1 = white.
REQ-010 Port in_ready  output  1  block can accept a pixel this cycle.
REQ-011 Port clear_req  input  1  request a full-screen clear to black.
REQ-012 Port clear_busy  output  1  clear pending or in progress.
REQ-013 Port fb_we  output  1  framebuffer write request.
REQ-014 Port fb_addr  output  19  framebuffer word address.
REQ-015 Port fb_data  output  1  pixel value to write.
REQ-016 Port fb_ack  input  1  framebuffer accepts the presented write this cycle.
REQ-017 Port drop_count  output  16  count of discarded out-of-range pixels.

Function
REQ-018 Accept: a pixel SHALL be transferred on any edge with in_valid and in_ready both high.
REQ-019 in_ready SHALL be high only in state RUN with FIFO occupancy below DEPTH; it is low when the FIFO is full, even if a pop occurs in the same cycle.
REQ-020 In-range pixel (in_x < WIDTH and in_y < HEIGHT): the block SHALL push {addr = in_y*WIDTH + in_x, color} into the FIFO, with addr truncated to 19 bits.
REQ-021 Out-of-range pixel: the block SHALL accept it, not enqueue it, and increment drop_count, saturating at 16'hFFFF.
REQ-022 In RUN, fb_we SHALL equal FIFO non-empty, with fb_addr and fb_data taken from the FIFO head.
REQ-023 A write completes on an edge with fb_we and fb_ack high; the FIFO head SHALL pop on that edge.
REQ-024 fb_we, fb_addr and fb_data SHALL hold stable while fb_we is high and fb_ack is low.
REQ-025 Latency: a pixel accepted into an empty FIFO at edge N SHALL appear on fb_we in the cycle following edge N.
REQ-026 Simultaneous push and pop SHALL leave occupancy unchanged and preserve FIFO order.
REQ-027 FSM states SHALL be RUN and CLEAR; clear_req high on any edge SHALL set a clear_pending flag.
REQ-028 RUN to CLEAR: when clear_pending is set and either fb_we is low or a write completes on that edge.
REQ-029 On entry to CLEAR, the FIFO SHALL be flushed (flushed entries are not counted in drop_count), clear_pending SHALL be cleared, and the clear address SHALL load 0.
REQ-030 In CLEAR: fb_we = 1, fb_data = 0, fb_addr = clear address; each completed write SHALL increment the clear address.
REQ-031 CLEAR to RUN: on completion of the write to address WIDTH*HEIGHT-1.
REQ-032 clear_req asserted while in CLEAR SHALL be ignored.
REQ-033 clear_busy SHALL equal clear_pending OR (state == CLEAR).

Reset
REQ-034 While reset is high, the block SHALL drive: state RUN, FIFO empty, clear_pending 0, clear address 0, drop_count 0.
REQ-035 In the cycle after reset deasserts, outputs SHALL be: fb_we 0, in_ready 1, clear_busy 0.
REQ-036 Reset asserted mid-write or mid-clear SHALL abandon the operation, with no further fb_we until new input arrives.

Verification
REQ-037 Single pixel: x=3, y=2, color=1 with fb_ack held high -> exactly one write, fb_addr=1283, fb_data=1, one cycle after accept.
REQ-038 Backpressure: fb_ack=0, push 9 pixels with DEPTH=8 -> in_ready low after the 8th; release fb_ack -> 8 writes in order, then the 9th is accepted.
REQ-039 Out of range: x=640, y=0, then x=0, y=480 -> no fb_we, drop_count=2; fb_ack held 0 during a 2-pixel run -> fb_addr/fb_data stable.
REQ-040 Clear (WIDTH=4, HEIGHT=3): clear_req pulse with 3 pixels queued -> FIFO flushed, 12 writes to addresses 0..11 with data 0, then clear_busy low and return to RUN.
REQ-041 Reset mid-clear at address 5 -> next cycle fb_we=0, clear_busy=0, in_ready=1, drop_count=0.
